mont_exp_ctrl: RTL

Sequencer for the 5-stage pipelined Montgomery multiplier: computes a modular exponentiation base^exp in the Montgomery domain by left-to-right square-and-multiply. It issues one Montgomery product at a time, waits out the multiplier latency, captures the product and reports the final accumulator. It sits between a CPU-side register interface and one multiplier instance; q and q' go straight to the multiplier and are not handled here.

---
 rtl/mont_exp_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply sequencer for a pipelined
// Montgomery multiplier. It issues one product at a time, waits out the
// multiplier latency, captures the product into the accumulator and reports
// the final accumulator with a one-cycle done pulse.
//
// Optional feature macro: MONT_EXP_SKIP_LZ_EN
//   defined   : the bit index starts at the most significant set bit of exp,
//               so leading-zero squarings of one_m are skipped; exp = 0 goes
//               straight to DONE with result = one_m.
//   undefined : always EXP_WIDTH squarings (latency depends only on popcount).
module mont_exp_ctrl #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32,
  parameter int MUL_LAT   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base_m,
  input  logic [WIDTH-1:0]     one_m,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [WIDTH-1:0]     mul_res
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int CNT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SQ   = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state_q,  state_d;
  logic [EXP_WIDTH-1:0] exp_q,    exp_d;
  logic [WIDTH-1:0]     base_q,   base_d;
  logic [WIDTH-1:0]     acc_q,    acc_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [WIDTH-1:0]     mul_a_q,  mul_a_d;
  logic [WIDTH-1:0]     mul_b_q,  mul_b_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;

`ifdef MONT_EXP_SKIP_LZ_EN
  // Index of the most significant set bit; 0 when the value is zero.
  function automatic logic [IDX_W-1:0] msb_index(input logic [EXP_WIDTH-1:0] v);
    msb_index = '0;
    for (int k = 0; k < EXP_WIDTH; k++) begin
      if (v[k]) msb_index = IDX_W'(k);
    end
  endfunction
`endif

  // Next-state and datapath decisions; operands for the next product are
  // launched on the same edge that captures the current one.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    exp_d    = exp_q;
    base_d   = base_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d  = exp;
          base_d = base_m;
          acc_d  = one_m;
`ifdef MONT_EXP_SKIP_LZ_EN
          idx_d  = msb_index(exp);
          if (exp == '0) begin
            // Nothing to compute: the accumulator is already the answer.
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = one_m;
          end else begin
            state_d = S_SQ;
            busy_d  = 1'b1;
            mul_a_d = one_m;
            mul_b_d = one_m;
            cnt_d   = CNT_W'(MUL_LAT);
          end
`else
          idx_d   = IDX_W'(EXP_WIDTH - 1);
          state_d = S_SQ;
          busy_d  = 1'b1;
          mul_a_d = one_m;
          mul_b_d = one_m;
          cnt_d   = CNT_W'(MUL_LAT);
`endif
        end
      end

      S_SQ, S_MUL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          acc_d = mul_res;
          cnt_d = CNT_W'(MUL_LAT);
          if (state_q == S_SQ && exp_q[idx_q]) begin
            // Bit set: multiply the fresh square by the base.
            state_d = S_MUL;
            mul_a_d = mul_res;
            mul_b_d = base_q;
          end else if (idx_q == '0) begin
            state_d  = S_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = mul_res;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = S_SQ;
            mul_a_d = mul_res;
            mul_b_d = mul_res;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the working registers (exp/base/acc/idx/cnt) are reset too even
    // though every start reloads them, so no X ever reaches the outputs.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      exp_q    <= '0;
      base_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      exp_q    <= exp_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;

endmodule
